// File: rtl/fan_ctrl_pkg.sv
// Shared widths, FSM state encodings and the duty slew helper for the fan duty scheduler.
package fan_ctrl_pkg;

    localparam int DUTY_W = 12;
    localparam int TEMP_W = 12;

    typedef logic [DUTY_W-1:0] duty_t;

    localparam duty_t DUTY_FULL = 12'hFFF;

    localparam logic [1:0] ST_OFF      = 2'd0;
    localparam logic [1:0] ST_KICK     = 2'd1;
    localparam logic [1:0] ST_RUN      = 2'd2;
    localparam logic [1:0] ST_FAILSAFE = 2'd3;

    // One slew step from cur toward tgt: moves by at most step, never past tgt.
    function automatic duty_t duty_step(input duty_t cur, input duty_t tgt, input duty_t step);
        logic [DUTY_W:0] diff;
        logic [DUTY_W:0] nxt;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            nxt  = (diff > {1'b0, step}) ? ({1'b0, cur} + {1'b0, step}) : {1'b0, tgt};
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
            nxt  = (diff > {1'b0, step}) ? ({1'b0, cur} - {1'b0, step}) : {1'b0, tgt};
        end
        if (nxt > {1'b0, DUTY_FULL}) begin
            nxt = {1'b0, DUTY_FULL};
        end
        return nxt[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/fan_slew_limiter.sv
// Holds the current duty word: free-running slew tick divider, direct load, and
// a bounded step toward the target on each tick while enabled.
module fan_slew_limiter
    import fan_ctrl_pkg::*;
#(
    parameter int    SLEW_DIV  = 16,
    parameter duty_t SLEW_STEP = 12'h040
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_load,
    input  duty_t i_load_val,
    input  duty_t i_target,
    input  logic  i_en,
    output duty_t o_duty
);

    localparam int DIV_W = (SLEW_DIV > 1) ? $clog2(SLEW_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

    logic [DIV_W-1:0] r_div;
    duty_t            r_duty;
    logic             w_tick;

    assign w_tick = (r_div == DIV_LAST);
    assign o_duty = r_duty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div  <= '0;
            r_duty <= DUTY_FULL;
        end else begin
            r_div <= w_tick ? '0 : r_div + 1'b1;
            // Load wins over slewing so state-forced duties take effect next cycle.
            if (i_load) begin
                r_duty <= i_load_val;
            end else if (i_en && w_tick) begin
                r_duty <= duty_step(r_duty, i_target, SLEW_STEP);
            end
        end
    end

endmodule

// File: rtl/fan_duty_sched.sv
// Fan PWM duty scheduler: temperature-to-target mapping, OFF/KICK/RUN/FAILSAFE FSM
// and stale-sample watchdog. Define FAN_SCHED_HYSTERESIS_EN to gate target updates by HYST.
module fan_duty_sched
    import fan_ctrl_pkg::*;
#(
    parameter duty_t MIN_DUTY    = 12'h400,
    parameter int    GAIN_SHIFT  = 2,
    parameter duty_t KICK_DUTY   = 12'hFFF,
    parameter int    KICK_CYCLES = 64,
    parameter int    SLEW_DIV    = 16,
    parameter duty_t SLEW_STEP   = 12'h040,
    parameter int    WDOG_CYCLES = 1024
`ifdef FAN_SCHED_HYSTERESIS_EN
    ,
    parameter logic [TEMP_W-1:0] HYST = 12'd8
`endif
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              enable_in,
    input  logic [TEMP_W-1:0] temp_in,
    input  logic              temp_valid_in,
    input  logic [TEMP_W-1:0] cfg_lo_in,
    input  logic [TEMP_W-1:0] cfg_hi_in,
    output logic [DUTY_W-1:0] duty_out,
    output logic [1:0]        state_out,
    output logic              fault_out
);

    localparam int KICK_W = $clog2(KICK_CYCLES + 1);
    localparam logic [KICK_W-1:0] KICK_LAST = KICK_W'(KICK_CYCLES - 1);
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_next;
    logic [KICK_W-1:0] r_kick_cnt;
    logic [WDOG_W-1:0] r_wdog_cnt;
    logic              r_fault;
    duty_t             r_target;
    duty_t             w_map;
    duty_t             w_load_val;
    logic [TEMP_W-1:0] w_diff;
    logic [23:0]       w_scaled;
    logic              w_wdog_exp;
    logic              w_apply;
    logic              w_load;
    logic              w_en;

    assign w_diff   = temp_in - cfg_lo_in;
    assign w_scaled = 24'(MIN_DUTY) + (24'(w_diff) << GAIN_SHIFT);

    // Upper threshold is checked first so an inverted lo/hi pair still yields full duty.
    always_comb begin
        w_map = MIN_DUTY;
        if (temp_in >= cfg_hi_in) begin
            w_map = DUTY_FULL;
        end else if (temp_in <= cfg_lo_in) begin
            w_map = MIN_DUTY;
        end else if (w_scaled > 24'(DUTY_FULL)) begin
            w_map = DUTY_FULL;
        end else begin
            w_map = w_scaled[DUTY_W-1:0];
        end
    end

    // temp_valid_in is a one-cycle strobe with no back-pressure: every asserted cycle is a sample.
`ifdef FAN_SCHED_HYSTERESIS_EN
    logic [TEMP_W-1:0] r_last_temp;
    logic [TEMP_W-1:0] w_temp_delta;
    logic              w_cross;

    assign w_temp_delta = (temp_in >= r_last_temp) ? (temp_in - r_last_temp) : (r_last_temp - temp_in);
    assign w_cross      = (temp_in >= cfg_hi_in) != (r_last_temp >= cfg_hi_in);
    assign w_apply      = temp_valid_in && ((w_temp_delta >= HYST) || w_cross);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_last_temp <= '0;
        end else if (w_apply) begin
            r_last_temp <= temp_in;
        end
    end
`else
    assign w_apply = temp_valid_in;
`endif

    assign w_wdog_exp = !temp_valid_in && (r_wdog_cnt >= WDOG_LAST);

    always_comb begin
        w_next = r_state;
        if (!enable_in) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:  w_next = ST_KICK;
                ST_KICK: begin
                    if (w_wdog_exp) begin
                        w_next = ST_FAILSAFE;
                    end else if (r_kick_cnt == KICK_LAST) begin
                        w_next = ST_RUN;
                    end
                end
                ST_RUN:  if (w_wdog_exp) w_next = ST_FAILSAFE;
                default: if (temp_valid_in) w_next = ST_RUN;
            endcase
        end
    end

    // Every state except RUN pins the duty word; RUN hands it to the slew limiter.
    always_comb begin
        w_load     = 1'b1;
        w_load_val = DUTY_FULL;
        case (w_next)
            ST_OFF:  w_load_val = '0;
            ST_KICK: w_load_val = KICK_DUTY;
            ST_RUN:  w_load     = 1'b0;
            default: w_load_val = DUTY_FULL;
        endcase
    end

    assign w_en = (r_state == ST_RUN);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state    <= ST_FAILSAFE;
            r_fault    <= 1'b0;
            r_target   <= DUTY_FULL;
            r_kick_cnt <= '0;
            r_wdog_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_apply) begin
                r_target <= w_map;
            end
            r_kick_cnt <= (r_state == ST_KICK && w_next == ST_KICK) ? r_kick_cnt + 1'b1 : '0;
            if (!enable_in || temp_valid_in) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != WDOG_LAST) begin
                r_wdog_cnt <= r_wdog_cnt + 1'b1;
            end
            // FAILSAFE is only entered from KICK/RUN through watchdog expiry.
            if (r_state != ST_FAILSAFE && w_next == ST_FAILSAFE) begin
                r_fault <= 1'b1;
            end else if (r_state == ST_FAILSAFE && w_next == ST_RUN) begin
                r_fault <= 1'b0;
            end
        end
    end

    fan_slew_limiter #(
        .SLEW_DIV  (SLEW_DIV),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew (
        .i_clk      (clk_in),
        .i_rst_n    (rst_n_in),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_target   (r_target),
        .i_en       (w_en),
        .o_duty     (duty_out)
    );

    assign state_out = r_state;
    assign fault_out = r_fault;

endmodule

// File: tb/tb_fan_duty_sched.sv
// Directed bench for fan_duty_sched: expected {state, fault, duty} words are queued by
// the stimulus and popped by a negedge monitor.
module tb_fan_duty_sched;
    import fan_ctrl_pkg::*;

    logic        clk_in        = 1'b0;
    logic        rst_n_in      = 1'b0;
    logic        enable_in     = 1'b1;
    logic [11:0] temp_in       = '0;
    logic        temp_valid_in = 1'b0;
    logic [11:0] cfg_lo_in     = 12'h200;
    logic [11:0] cfg_hi_in     = 12'h800;
    logic [11:0] duty_out;
    logic [1:0]  state_out;
    logic        fault_out;

`ifdef FAN_SCHED_HYSTERESIS_EN
    localparam logic [11:0] HOLD_EXP = 12'h800;
`else
    localparam logic [11:0] HOLD_EXP = 12'h814;
`endif

    fan_duty_sched dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .enable_in     (enable_in),
        .temp_in       (temp_in),
        .temp_valid_in (temp_valid_in),
        .cfg_lo_in     (cfg_lo_in),
        .cfg_hi_in     (cfg_hi_in),
        .duty_out      (duty_out),
        .state_out     (state_out),
        .fault_out     (fault_out)
    );

    // clock / cycle counter since reset release
    always #5 clk_in = ~clk_in;

    int cyc;
    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    // scoreboard
    logic [14:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [14:0] mon_exp;
    logic [14:0] mon_got;
    string       mon_name;

    always @(negedge clk_in) begin
        while (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_got  = {state_out, fault_out, duty_out};
            n_checks++;
            if (mon_got !== mon_exp) begin
                n_fail++;
                $display("FAIL %s: got state=%0d fault=%0d duty=%03h, expected state=%0d fault=%0d duty=%03h",
                         mon_name, mon_got[14:13], mon_got[12], mon_got[11:0],
                         mon_exp[14:13], mon_exp[12], mon_exp[11:0]);
            end
        end
    end

    // driver tasks
    task automatic expect_out(input string nm, input logic [1:0] st, input logic flt, input logic [11:0] d);
        exp_q.push_back({st, flt, d});
        name_q.push_back(nm);
    endtask

    task automatic goto(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 5000) begin
            @(posedge clk_in);
            #1;
            guard++;
        end
        if (cyc < k) begin
            n_checks++;
            n_fail++;
            $display("FAIL goto: cycle %0d, required %0d", cyc, k);
        end
    endtask

    task automatic send(input logic [11:0] t);
        temp_in       = t;
        temp_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        temp_valid_in = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
    endtask

    initial begin
        // reset and FAILSAFE exit with first sample
        repeat (2) @(posedge clk_in);
        #1;
        expect_out("reset", ST_FAILSAFE, 1'b0, 12'hFFF);
        release_reset();
        goto(10);
        expect_out("fs_idle", ST_FAILSAFE, 1'b0, 12'hFFF);
        send(12'h300);
        expect_out("fs_exit", ST_RUN, 1'b0, 12'hFFF);
        goto(511);
        expect_out("slew_83f", ST_RUN, 1'b0, 12'h83F);
        goto(512);
        expect_out("slew_800", ST_RUN, 1'b0, 12'h800);

        // watchdog expiry, recovery, minimum target, coincident sample
        goto(1034);
        expect_out("wd_pre", ST_RUN, 1'b0, 12'h800);
        goto(1035);
        expect_out("wd_fault", ST_FAILSAFE, 1'b1, 12'hFFF);
        goto(1040);
        send(12'h000);
        expect_out("wd_clear", ST_RUN, 1'b0, 12'hFFF);
        goto(1807);
        expect_out("min_43f", ST_RUN, 1'b0, 12'h43F);
        goto(1808);
        expect_out("min_400", ST_RUN, 1'b0, 12'h400);
        goto(2064);
        send(12'h900);
        expect_out("wd_coincident", ST_RUN, 1'b0, 12'h400);
        goto(2831);
        expect_out("full_fc0", ST_RUN, 1'b0, 12'hFC0);
        goto(2832);
        expect_out("full_fff", ST_RUN, 1'b0, 12'hFFF);

        // inverted thresholds: hi check has priority
        goto(2840);
        cfg_lo_in = 12'h900;
        cfg_hi_in = 12'h800;
        send(12'h850);
        goto(2880);
        expect_out("inv_thr", ST_RUN, 1'b0, 12'hFFF);
        cfg_lo_in = 12'h200;
        cfg_hi_in = 12'h800;
        goto(2890);
        send(12'h300);

        // disable, kick of exactly 64 cycles, slew down after kick
        goto(2900);
        enable_in = 1'b0;
        goto(2901);
        expect_out("dis_off", ST_OFF, 1'b0, 12'h000);
        goto(2910);
        enable_in = 1'b1;
        goto(2911);
        expect_out("kick_start", ST_KICK, 1'b0, 12'hFFF);
        goto(2974);
        expect_out("kick_last", ST_KICK, 1'b0, 12'hFFF);
        goto(2975);
        expect_out("kick_run", ST_RUN, 1'b0, 12'hFFF);
        goto(3471);
        expect_out("kick_slew_83f", ST_RUN, 1'b0, 12'h83F);
        goto(3472);
        expect_out("kick_slew_800", ST_RUN, 1'b0, 12'h800);

        // enable low mid-KICK, then reset mid-KICK
        goto(3480);
        send(12'h300);
        goto(3490);
        enable_in = 1'b0;
        goto(3491);
        expect_out("run_off", ST_OFF, 1'b0, 12'h000);
        goto(3492);
        enable_in = 1'b1;
        goto(3493);
        expect_out("kick_again", ST_KICK, 1'b0, 12'hFFF);
        goto(3500);
        enable_in = 1'b0;
        goto(3501);
        expect_out("kick_abort", ST_OFF, 1'b0, 12'h000);
        goto(3510);
        enable_in = 1'b1;
        goto(3519);
        expect_out("kick_mid", ST_KICK, 1'b0, 12'hFFF);
        goto(3520);
        rst_n_in = 1'b0;
        expect_out("rst_kick", ST_FAILSAFE, 1'b0, 12'hFFF);

        // saturation of the gain term, then reset mid-slew
        release_reset();
        goto(5);
        send(12'h300);
        expect_out("p3_run", ST_RUN, 1'b0, 12'hFFF);
        goto(50);
        expect_out("slew_mid", ST_RUN, 1'b0, 12'hF3F);
        cfg_lo_in = 12'h000;
        cfg_hi_in = 12'hFFF;
        send(12'h500);
        goto(70);
        expect_out("tgt_sat", ST_RUN, 1'b0, 12'hF7F);
        goto(71);
        rst_n_in = 1'b0;
        expect_out("rst_slew", ST_FAILSAFE, 1'b0, 12'hFFF);

        // small temperature steps (held back only with hysteresis)
        cfg_lo_in = 12'h200;
        cfg_hi_in = 12'h800;
        release_reset();
        goto(5);
        send(12'h300);
        goto(7);
        send(12'h305);
        goto(512);
        expect_out("hyst_hold", ST_RUN, 1'b0, HOLD_EXP);
        goto(520);
        send(12'h308);
        goto(530);
        expect_out("hyst_apply", ST_RUN, 1'b0, 12'h820);

        // final report
        repeat (2) @(posedge clk_in);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
